// File: rtl/instr_fetch_unit.sv
// RISC-V fetch stage: holds the PC, reads instruction words over a req/ack
// handshake and hands them to decode through a valid/ready instruction register.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          TIMEOUT   = 16,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        pc_load,
   input  logic [31:0] pc_target,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [24:0] imm_field,
   output logic        fetch_err
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

   localparam int                CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [31:0]       pc_q, pc_d;
   logic [31:0]       pend_q, pend_d;
   logic              flush_q, flush_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       instr_q, instr_d;
   logic [31:0]       instr_pc_q, instr_pc_d;
   logic              instr_valid_q, instr_valid_d;
   logic              fetch_err_q, fetch_err_d;
   logic [31:0]       target;

   assign target = pc_target & ~32'h3;

   always_comb begin
      // NOTE: every _d starts from its _q so no path through the case leaves a
      // signal unassigned, which would otherwise infer a latch.
      state_d       = state_q;
      pc_d          = pc_q;
      pend_d        = pend_q;
      flush_d       = flush_q;
      cnt_d         = cnt_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      fetch_err_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (pc_load) begin
               pc_d    = target;
               state_d = FETCH;
            end else if (!stall) begin
               state_d = FETCH;
            end
         end

         FETCH: begin
            if (mem_ack) begin
               cnt_d = '0;
               if (flush_q || pc_load) begin
                  // Redirected while the read was in flight: drop the data.
                  pc_d    = pc_load ? target : pend_q;
                  flush_d = 1'b0;
               end else begin
                  instr_d       = mem_rdata;
                  instr_pc_d    = pc_q;
                  pc_d          = pc_q + 32'd4;
                  instr_valid_d = 1'b1;
                  state_d       = HOLD;
               end
            end else begin
               if (pc_load) begin
                  pend_d  = target;
                  flush_d = 1'b1;
               end
               if (cnt_q == CNT_MAX) begin
                  // Give up on this read; IDLE re-issues it, after any redirect.
                  fetch_err_d = 1'b1;
                  cnt_d       = '0;
                  flush_d     = 1'b0;
                  state_d     = IDLE;
                  if (pc_load)      pc_d = target;
                  else if (flush_q) pc_d = pend_q;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         HOLD: begin
            if (pc_load) begin
               instr_d       = NOP_INSTR;
               instr_valid_d = 1'b0;
               pc_d          = target;
               state_d       = FETCH;
            end else if (instr_ready) begin
               instr_valid_d = 1'b0;
               state_d       = stall ? IDLE : FETCH;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: state is updated only with non-blocking assignments so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         pend_q        <= RESET_PC;
         flush_q       <= 1'b0;
         cnt_q         <= '0;
         instr_q       <= NOP_INSTR;
         instr_pc_q    <= 32'h0;
         instr_valid_q <= 1'b0;
         fetch_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         pend_q        <= pend_d;
         flush_q       <= flush_d;
         cnt_q         <= cnt_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
         fetch_err_q   <= fetch_err_d;
      end
   end

   assign mem_req     = (state_q == FETCH);
   assign mem_addr    = pc_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = instr_valid_q;
   assign fetch_err   = fetch_err_q;
   assign imm_field   = instr_q[31:7];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: inputs change on the falling edge,
// outputs are sampled on the falling edge before new inputs are applied.
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        pc_load;
   logic [31:0] pc_target;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [24:0] imm_field;
   logic        fetch_err;

   int compared   = 0;
   int mismatched = 0;

   instr_fetch_unit #(
      .RESET_PC  (32'h0000_0000),
      .TIMEOUT   (16),
      .NOP_INSTR (32'h0000_0013)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .pc_load     (pc_load),
      .pc_target   (pc_target),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .imm_field   (imm_field),
      .fetch_err   (fetch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected finish");
      $fatal(1, "watchdog");
   end

   // Wait (bounded) for mem_req to be high at a falling edge.
   task automatic wait_req(input string tag);
      int n;
      n = 0;
      while (!mem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      compared++;
      if (mem_req !== 1'b1) begin
         mismatched++;
         $display("FAIL %s_req_rise: mem_req=%b expected 1 within 20 cycles", tag, mem_req);
      end
   endtask

   // One normal fetch: ack after 'delay' extra cycles, then check the capture.
   task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data,
                           input int delay, input string tag);
      wait_req(tag);
      compared++;
      if (mem_addr !== addr) begin
         mismatched++;
         $display("FAIL %s_addr: mem_addr=%h expected %h", tag, mem_addr, addr);
      end
      repeat (delay) @(negedge clk);
      mem_ack   = 1'b1;
      mem_rdata = data;
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      compared++;
      if (instr_valid !== 1'b1) begin
         mismatched++;
         $display("FAIL %s_valid: instr_valid=%b expected 1", tag, instr_valid);
      end
      compared++;
      if (instr !== data) begin
         mismatched++;
         $display("FAIL %s_instr: instr=%h expected %h", tag, instr, data);
      end
      compared++;
      if (instr_pc !== addr) begin
         mismatched++;
         $display("FAIL %s_instr_pc: instr_pc=%h expected %h", tag, instr_pc, addr);
      end
      compared++;
      if (imm_field !== data[31:7]) begin
         mismatched++;
         $display("FAIL %s_imm: imm_field=%h expected %h", tag, imm_field, data[31:7]);
      end
      compared++;
      if (mem_req !== 1'b0) begin
         mismatched++;
         $display("FAIL %s_req_drop: mem_req=%b expected 0 in HOLD", tag, mem_req);
      end
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      stall       = 1'b1;
      pc_load     = 1'b0;
      pc_target   = 32'h0;
      mem_ack     = 1'b0;
      mem_rdata   = 32'h0;
      instr_ready = 1'b1;
      repeat (2) @(negedge clk);
      compared++;
      if (mem_req !== 1'b0) begin mismatched++; $display("FAIL rst_req: mem_req=%b expected 0", mem_req); end
      compared++;
      if (mem_addr !== 32'h0) begin mismatched++; $display("FAIL rst_addr: mem_addr=%h expected 0", mem_addr); end
      compared++;
      if (instr !== 32'h0000_0013) begin mismatched++; $display("FAIL rst_instr: instr=%h expected 00000013", instr); end
      compared++;
      if (instr_pc !== 32'h0) begin mismatched++; $display("FAIL rst_instr_pc: instr_pc=%h expected 0", instr_pc); end
      compared++;
      if (instr_valid !== 1'b0) begin mismatched++; $display("FAIL rst_valid: instr_valid=%b expected 0", instr_valid); end
      compared++;
      if (fetch_err !== 1'b0) begin mismatched++; $display("FAIL rst_err: fetch_err=%b expected 0", fetch_err); end
      compared++;
      if (imm_field !== 25'h0) begin mismatched++; $display("FAIL rst_imm: imm_field=%h expected 0", imm_field); end
      rst_n = 1'b1;
      // stall held in IDLE: no request may go out
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         compared++;
         if (mem_req !== 1'b0) begin mismatched++; $display("FAIL rst_stall_req[%0d]: mem_req=%b expected 0", i, mem_req); end
      end
      stall = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] sext;
      do_fetch(32'h0000_0000, 32'hFFF0_0513, 1, "f0");
      compared++;
      if (imm_field !== 25'h1FF_E00A) begin mismatched++; $display("FAIL f0_imm_const: imm_field=%h expected 1ffe00a", imm_field); end
      sext = {{20{imm_field[24]}}, imm_field[24:13]};
      compared++;
      if (sext !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL f0_sext: itype imm=%h expected ffffffff", sext); end
      do_fetch(32'h0000_0004, 32'h00A0_0093, 1, "f4");
      do_fetch(32'h0000_0008, 32'h1234_5678, 1, "f8");
   endtask

   task automatic test_hold();
      @(negedge clk);
      instr_ready = 1'b0;
      do_fetch(32'h0000_000C, 32'hCAFE_F00D, 1, "fc");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         compared++;
         if (instr_valid !== 1'b1 || instr !== 32'hCAFE_F00D || mem_req !== 1'b0) begin
            mismatched++;
            $display("FAIL hold[%0d]: valid=%b instr=%h req=%b expected 1 cafef00d 0", i, instr_valid, instr, mem_req);
         end
      end
      instr_ready = 1'b1;
      @(negedge clk);
      compared++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0010 || instr_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL hold_release: req=%b addr=%h valid=%b expected 1 00000010 0", mem_req, mem_addr, instr_valid);
      end
   endtask

   task automatic test_flush();
      pc_load   = 1'b1;
      pc_target = 32'h0000_0102;
      @(negedge clk);
      pc_load   = 1'b0;
      compared++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0010) begin
         mismatched++;
         $display("FAIL flush_stable: req=%b addr=%h expected 1 00000010", mem_req, mem_addr);
      end
      @(negedge clk);
      @(negedge clk);
      mem_ack   = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      compared++;
      if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h0000_0100) begin
         mismatched++;
         $display("FAIL flush_discard: valid=%b req=%b addr=%h expected 0 1 00000100", instr_valid, mem_req, mem_addr);
      end
      compared++;
      if (instr === 32'hDEAD_BEEF) begin mismatched++; $display("FAIL flush_instr: instr=%h expected not deadbeef", instr); end
      instr_ready = 1'b0;
      do_fetch(32'h0000_0100, 32'h0010_0113, 1, "f100");
      // redirect from HOLD overrides the held instruction
      pc_load   = 1'b1;
      pc_target = 32'h0000_0200;
      @(negedge clk);
      pc_load   = 1'b0;
      compared++;
      if (instr !== 32'h0000_0013 || instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h0000_0200) begin
         mismatched++;
         $display("FAIL hold_redirect: instr=%h valid=%b req=%b addr=%h expected 00000013 0 1 00000200", instr, instr_valid, mem_req, mem_addr);
      end
   endtask

   task automatic test_timeout();
      int n;
      n = 0;
      while (mem_req && n < 40) begin
         n++;
         @(negedge clk);
      end
      compared++;
      if (n != 16) begin mismatched++; $display("FAIL to_len: mem_req high %0d cycles expected 16", n); end
      compared++;
      if (fetch_err !== 1'b1 || mem_req !== 1'b0 || mem_addr !== 32'h0000_0200) begin
         mismatched++;
         $display("FAIL to_err: err=%b req=%b addr=%h expected 1 0 00000200", fetch_err, mem_req, mem_addr);
      end
      @(negedge clk);
      compared++;
      if (fetch_err !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h0000_0200) begin
         mismatched++;
         $display("FAIL to_retry: err=%b req=%b addr=%h expected 0 1 00000200", fetch_err, mem_req, mem_addr);
      end
      instr_ready = 1'b1;
      do_fetch(32'h0000_0200, 32'h0BAD_F00D, 2, "f200");
   endtask

   task automatic test_wrap_stall();
      @(negedge clk);
      pc_load   = 1'b1;
      pc_target = 32'hFFFF_FFFF;
      @(negedge clk);
      pc_load   = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 32'h1111_1111;
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      compared++;
      if (mem_req !== 1'b1 || mem_addr !== 32'hFFFF_FFFC || instr_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL wrap_redirect: req=%b addr=%h valid=%b expected 1 fffffffc 0", mem_req, mem_addr, instr_valid);
      end
      do_fetch(32'hFFFF_FFFC, 32'h0000_0073, 1, "ffc");
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         compared++;
         if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
            mismatched++;
            $display("FAIL idle_stall[%0d]: req=%b addr=%h expected 0 00000000", i, mem_req, mem_addr);
         end
      end
      stall = 1'b0;
      @(negedge clk);
      compared++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
         mismatched++;
         $display("FAIL stall_release: req=%b addr=%h expected 1 00000000", mem_req, mem_addr);
      end
   endtask

   task automatic test_mid_reset();
      pc_load   = 1'b1;
      pc_target = 32'h0000_0400;
      @(negedge clk);
      pc_load   = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      compared++;
      if (mem_req !== 1'b0 || mem_addr !== 32'h0 || instr_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL mid_reset: req=%b addr=%h valid=%b expected 0 00000000 0", mem_req, mem_addr, instr_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_hold();
      test_flush();
      test_timeout();
      test_wrap_stall();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage of the RISC-V core. Holds the PC and issues word reads to the memory controller over a req/ack handshake. Latches each returned instruction into an instruction register and presents it to decode with a valid/ready handshake. Its instr[31:7] slice drives the sign-extend unit's instr_unextend input directly.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 16, maximum cycles mem_req may stay high without mem_ack before a retry (must be >= 2)
NOP_INSTR, 32'h0000_0013, instruction register value after reset or flush (addi x0,x0,0)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
stall  input  1  hazard stall; blocks starting a new fetch
pc_load  input  1  branch/jump redirect strobe
pc_target  input  32  redirect address; bits [1:0] forced to 0
mem_req  output  1  read request to memory controller
mem_addr  output  32  word-aligned fetch address
mem_ack  input  1  read data valid, one-cycle pulse
mem_rdata  input  32  read data, sampled when mem_ack=1
instr_valid  output  1  instr/instr_pc hold a valid instruction
instr_ready  input  1  decode accepts the instruction
instr  output  32  instruction register
instr_pc  output  32  address of instr
imm_field  output  25  instr[31:7], wired to sign-extend instr_unextend
fetch_err  output  1  one-cycle pulse on timeout

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=IDLE, mem_req=0, mem_addr=RESET_PC, instr=NOP_INSTR, instr_pc=0, instr_valid=0, fetch_err=0, timeout counter=0, flush flag=0.
- mem_addr always equals pc. mem_req=1 exactly in FETCH state. All other outputs are registered. imm_field is combinational from instr.
- States: IDLE, FETCH, HOLD.
- IDLE:
  - pc_load: pc<=target, ->FETCH.
  - else !stall: ->FETCH.
  - else stay.
- FETCH:
  - mem_req=1; pc and mem_addr stay stable until ack. Counter increments each cycle without ack.
  - mem_ack with flush flag=0 and pc_load=0: instr<=mem_rdata, instr_pc<=pc, pc<=pc+4 (mod 2^32, wraps at 32'hFFFF_FFFC->0), instr_valid<=1, counter<=0, ->HOLD.
  - mem_ack with flush flag=1 or pc_load=1 (same cycle): discard data, clear flush, counter<=0, stay FETCH.
  - pc_load without ack: pc_target is latched as pending target, flush<=1. The transaction is not aborted.
  - When a flushed fetch is acked, pc<=pending target (or pc_target if pc_load is in that cycle).
  - Counter==TIMEOUT-1 with no ack: fetch_err pulses 1 cycle, mem_req drops, counter<=0, ->IDLE, pc unchanged (retry). A pending flush is applied to pc at this point.
  - stall is ignored in FETCH.
- HOLD:
  - instr_valid=1; instr and instr_pc stay stable until instr_ready.
  - instr_ready=1: instr_valid<=0; ->FETCH if !stall, else ->IDLE.
  - pc_load (highest priority, even with instr_ready): instr<=NOP_INSTR, instr_valid<=0, pc<=target, ->FETCH.
- Throughput: the ack cycle is followed by instr_valid=1 in the next cycle. The next mem_req rises in the cycle after the instr_ready handshake. One instruction per 3 cycles with a single-cycle ack.
- rst_n asserted mid-transaction: mem_req drops immediately. The memory controller is reset by the same rst_n.

Test Plan:
- Reset release, RESET_PC=0, ack after 1 cycle, instr_ready=1 tied -> fetches at 0,4,8. instr=mem_rdata, instr_pc matches, imm_field=instr[31:7].
- mem_rdata=32'hFFF0_0513 at addr 0 -> instr=32'hFFF0_0513, imm_field=25'h1FFE00A; sign-extend (imm_src=00) output 32'hFFFF_FFFF.
- HOLD with instr_ready=0 for 5 cycles -> instr_valid=1 and instr stable, no mem_req. Then ready=1 -> mem_req next cycle at pc+4.
- pc_load=1, target=32'h0000_0102 during outstanding FETCH at 0x10, ack 3 cycles later -> data discarded, instr_valid stays 0, next mem_addr=32'h0000_0100.
- No ack for 16 cycles -> fetch_err pulses once, mem_req low 1 cycle, retry at same mem_addr. Ack on retry -> normal capture.
- pc=32'hFFFF_FFFC fetch completes -> next mem_addr=0. stall=1 in IDLE holds mem_req=0 until stall=0.
